// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, per-way saturating
// direction counters, tree-PLRU replacement and a one-set-per-cycle flush walker.
module btb_assoc #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] predict_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  flush,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      cnt_reg, cnt_next;
    logic [NUM_WAYS-1:0]   valid_reg [NUM_SETS];
    logic [NUM_WAYS-2:0]   plru_reg  [NUM_SETS];
    logic [TAG_W-1:0]      tag_mem    [NUM_SETS][NUM_WAYS];
    logic [ADDR_WIDTH-1:0] target_mem [NUM_SETS][NUM_WAYS];
    logic [CTR_BITS-1:0]   ctr_mem    [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]    p_idx, u_idx;
    logic [TAG_W-1:0]    p_tag, u_tag;
    logic [NUM_WAYS-1:0] p_hit_vec, u_hit_vec;
    logic [WAY_W-1:0]    p_hit_way, u_hit_way, inv_way, victim_way, write_way;
    logic [NUM_WAYS-2:0] plru_next;
    logic [CTR_BITS-1:0] ctr_old, ctr_new;
    logic                do_write, t_dir;
    int                  v_node, t_node;
    logic                unused_pc_bits;

    assign p_idx = predict_pc[IDX_W+1:2];
    assign p_tag = predict_pc[ADDR_WIDTH-1:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[ADDR_WIDTH-1:IDX_W+2];
    assign unused_pc_bits = ^{predict_pc[1:0], update_pc[1:0]};

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign p_hit_vec[gi] = valid_reg[p_idx][gi] && (tag_mem[p_idx][gi] == p_tag);
            assign u_hit_vec[gi] = valid_reg[u_idx][gi] && (tag_mem[u_idx][gi] == u_tag);
        end
    endgenerate

    assign busy = (state_reg == FLUSH);

    always_comb begin
        p_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (p_hit_vec[w]) p_hit_way = WAY_W'(w);
        predict_hit    = (|p_hit_vec) && (state_reg == IDLE);
        predict_taken  = predict_hit && ctr_mem[p_idx][p_hit_way][CTR_BITS-1];
        predict_target = predict_hit ? target_mem[p_idx][p_hit_way] : '0;
    end

    // Update side: pick the way, then derive its new counter and the set's new PLRU bits.
    always_comb begin
        u_hit_way = '0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (u_hit_vec[w])             u_hit_way = WAY_W'(w);
            if (!valid_reg[u_idx][w])     inv_way   = WAY_W'(w);
        end

        // Follow the PLRU bits from the root: 0 steers left, 1 steers right.
        v_node = 0;
        for (int l = 0; l < WAY_W; l++)
            v_node = 2 * v_node + 1 + int'(plru_reg[u_idx][v_node]);
        victim_way = WAY_W'(v_node - (NUM_WAYS - 1));

        if (|u_hit_vec)                 write_way = u_hit_way;
        else if (~&valid_reg[u_idx])    write_way = inv_way;
        else                            write_way = victim_way;

        plru_next = plru_reg[u_idx];
        t_node    = 0;
        t_dir     = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            t_dir             = write_way[WAY_W-1-l];
            plru_next[t_node] = ~t_dir;
            t_node            = 2 * t_node + 1 + int'(t_dir);
        end

        ctr_old = ctr_mem[u_idx][u_hit_way];
        ctr_new = CTR_WEAK;
        if (|u_hit_vec) begin
            if (update_taken) ctr_new = (&ctr_old) ? ctr_old : ctr_old + 1'b1;
            else              ctr_new = (|ctr_old) ? ctr_old - 1'b1 : ctr_old;
        end

        do_write = update_valid && (state_reg == IDLE) && !flush
                   && ((|u_hit_vec) || update_taken);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end
            end
            FLUSH: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == IDX_W'(NUM_SETS - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                plru_reg[s]  <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == FLUSH) begin
                valid_reg[cnt_reg] <= '0;
                plru_reg[cnt_reg]  <= '0;
            end else if (do_write) begin
                valid_reg[u_idx][write_way] <= 1'b1;
                plru_reg[u_idx]             <= plru_next;
            end
        end
    end

    // Payload arrays carry no reset; valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_mem[u_idx][write_way] <= u_tag;
            ctr_mem[u_idx][write_way] <= ctr_new;
            if (update_taken) target_mem[u_idx][write_way] <= update_target;
        end
    end
endmodule
